// File: rtl/canvas_scan.sv
// Frame-level scan sequencer: walks every canvas cell row-major, waits HOLD
// cycles per cell for the ray unit, then offers the captured ray downstream.
`timescale 1ns/1ps

module canvas_scan #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [12:0] view_loc,
  input  logic [30:0] ray_in,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [30:0] sample_ray,
  output logic [12:0] sample_loc,
  output logic [12:0] sample_addr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_e;

  localparam int              CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
  localparam logic [6:0]      X_LAST   = 7'(COLS - 1);
  localparam logic [5:0]      Y_LAST   = 6'(ROWS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic [12:0]      addr_q, addr_d;
  logic [30:0]      ray_q, ray_d;
  logic [12:0]      loc_q, loc_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_cell;

  assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    ray_d   = ray_q;
    loc_d   = loc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_LOAD;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          ray_d   = ray_in;
          loc_d   = {x_q, y_q};
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (sample_ready) begin
          if (last_cell) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 6'd1;
            end else begin
              x_d = x_q + 7'd1;
            end
            // Running address replaces the y*COLS + x multiply.
            addr_d  = addr_q + 13'd1;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides start and any same-cycle handshake.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
    end
  end

  // Status outputs are flops decoded from the next state, so they line up
  // with the state register and carry no input-to-output path.
  always_comb begin
    valid_d = (state_d == S_EMIT);
    busy_d  = (state_d == S_SETTLE) || (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      ray_q   <= '0;
      loc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      ray_q   <= ray_d;
      loc_q   <= loc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign view_loc     = {x_q, y_q};
  assign sample_valid = valid_q;
  assign sample_ray   = ray_q;
  assign sample_loc   = loc_q;
  assign sample_addr  = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_canvas_scan.sv
// Directed bench for canvas_scan: a small 4x2 instance for timing/control
// scenarios and a full 80x60 instance for row wrap and the final address.
`timescale 1ns/1ps

module tb_canvas_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small instance: 4x2 cells, HOLD=3 (4 cycles per cell, done in cycle 33)
  logic        a_start, a_abort, a_ready;
  logic [12:0] a_view_loc, a_sloc, a_saddr;
  logic [30:0] a_ray, a_sray;
  logic        a_valid, a_busy, a_done;
  assign a_ray = {a_view_loc, 18'h0};

  canvas_scan #(.COLS(4), .ROWS(2), .HOLD(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .view_loc(a_view_loc), .ray_in(a_ray), .sample_valid(a_valid),
    .sample_ready(a_ready), .sample_ray(a_sray), .sample_loc(a_sloc),
    .sample_addr(a_saddr), .busy(a_busy), .done(a_done)
  );

  // Full-size instance: 80x60 cells, minimum HOLD=1 (2 cycles per cell)
  logic        b_start, b_abort, b_ready;
  logic [12:0] b_view_loc, b_sloc, b_saddr;
  logic [30:0] b_ray, b_sray;
  logic        b_valid, b_busy, b_done;
  assign b_ray = {b_view_loc, 18'h0};

  canvas_scan #(.COLS(80), .ROWS(60), .HOLD(1)) u_full (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .view_loc(b_view_loc), .ray_in(b_ray), .sample_valid(b_valid),
    .sample_ready(b_ready), .sample_ray(b_sray), .sample_loc(b_sloc),
    .sample_addr(b_saddr), .busy(b_busy), .done(b_done)
  );

  // Per-cycle observation logs of the small instance
  logic [12:0] lg_view [0:63];
  logic [12:0] lg_sloc [0:63];
  logic [30:0] lg_sray [0:63];
  logic        lg_valid[0:63];
  logic        lg_busy [0:63];
  logic [12:0] smp_addr[0:7];
  logic [12:0] smp_loc [0:7];
  logic [30:0] smp_ray [0:7];
  int          smp_cyc [0:7];
  int          nsamp, done_cnt, done_cyc;

  function automatic logic [12:0] loc_of(input int i);
    return {7'(i % 4), 6'(i / 4)};
  endfunction

  // Drives one run of the small instance for cycles 0..len (start in cycle 0)
  // and records outputs; it makes no judgements itself.
  task automatic run_a(input int stall_from, input int stall_to, input int p1,
                       input int p2, input int abort_cyc, input int len);
    nsamp = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) @(negedge clk);
      a_start = (c == 0) || (c == p1) || (c == p2);
      a_ready = !(c >= stall_from && c <= stall_to);
      a_abort = (c == abort_cyc);
      lg_view[c]  = a_view_loc;
      lg_sloc[c]  = a_sloc;
      lg_sray[c]  = a_sray;
      lg_valid[c] = a_valid;
      lg_busy[c]  = a_busy;
      if (a_valid && a_ready && !a_abort) begin
        if (nsamp < 8) begin
          smp_addr[nsamp] = a_saddr;
          smp_loc[nsamp]  = a_sloc;
          smp_ray[nsamp]  = a_sray;
          smp_cyc[nsamp]  = c;
        end
        nsamp++;
      end
      if (a_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    a_start = 1'b0; a_abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_start = 0; a_abort = 0; a_ready = 0;
    b_start = 0; b_abort = 0; b_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_view_loc, a_valid, a_sray, a_sloc, a_saddr, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_small: got loc=%h valid=%b ray=%h sloc=%h addr=%0d busy=%b done=%b, expected all 0",
               a_view_loc, a_valid, a_sray, a_sloc, a_saddr, a_busy, a_done);
    end
    checks++;
    if ({b_view_loc, b_valid, b_sray, b_sloc, b_saddr, b_busy, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_full: got loc=%h valid=%b ray=%h sloc=%h addr=%0d busy=%b done=%b, expected all 0",
               b_view_loc, b_valid, b_sray, b_sloc, b_saddr, b_busy, b_done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_valid, a_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/valid/done=%b expected 000", {a_busy, a_valid, a_done});
    end
  endtask

  task automatic test_free_frame;
    @(negedge clk);
    run_a(-1, -1, -1, -1, -1, 60);
    checks++;
    if (nsamp != 8) begin
      errors++; $display("FAIL frame_samples: got %0d expected 8", nsamp);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (smp_addr[i] !== 13'(i)) begin
        errors++; $display("FAIL frame_addr[%0d]: got %0d expected %0d", i, smp_addr[i], i);
      end
      checks++;
      if (smp_loc[i] !== loc_of(i)) begin
        errors++; $display("FAIL frame_loc[%0d]: got %h expected %h", i, smp_loc[i], loc_of(i));
      end
      checks++;
      if (smp_ray[i] !== {loc_of(i), 18'h0}) begin
        errors++; $display("FAIL frame_ray[%0d]: got %h expected %h", i, smp_ray[i], {loc_of(i), 18'h0});
      end
      checks++;
      if (smp_cyc[i] != 4 * i + 4) begin
        errors++; $display("FAIL frame_cycle[%0d]: got %0d expected %0d", i, smp_cyc[i], 4 * i + 4);
      end
    end
    checks++;
    if (done_cyc != 33 || done_cnt != 1) begin
      errors++; $display("FAIL frame_done: got cycle %0d count %0d expected cycle 33 count 1", done_cyc, done_cnt);
    end
    checks++;
    if ({lg_busy[0], lg_busy[1], lg_busy[32], lg_busy[33], lg_busy[34]} !== 5'b01100) begin
      errors++; $display("FAIL frame_busy: got c0/1/32/33/34=%b expected 01100",
                         {lg_busy[0], lg_busy[1], lg_busy[32], lg_busy[33], lg_busy[34]});
    end
    checks++;
    if ({lg_valid[3], lg_valid[4]} !== 2'b01) begin
      errors++; $display("FAIL frame_first_valid: got c3/c4=%b expected 01", {lg_valid[3], lg_valid[4]});
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    run_a(12, 16, -1, -1, -1, 60);
    for (int c = 12; c <= 16; c++) begin
      checks++;
      if (lg_valid[c] !== 1'b1 || lg_sloc[c] !== loc_of(2) || lg_view[c] !== loc_of(2) ||
          lg_sray[c] !== {loc_of(2), 18'h0}) begin
        errors++;
        $display("FAIL stall_hold c%0d: got valid=%b sloc=%h view=%h ray=%h expected 1 %h %h %h",
                 c, lg_valid[c], lg_sloc[c], lg_view[c], lg_sray[c], loc_of(2), loc_of(2), {loc_of(2), 18'h0});
      end
    end
    checks++;
    if (smp_cyc[2] != 17 || smp_cyc[3] != 21) begin
      errors++; $display("FAIL stall_accept: got cell2 %0d cell3 %0d expected 17 21", smp_cyc[2], smp_cyc[3]);
    end
    checks++;
    if (done_cyc != 38 || done_cnt != 1 || nsamp != 8) begin
      errors++; $display("FAIL stall_done: got cycle %0d count %0d samples %0d expected 38 1 8",
                         done_cyc, done_cnt, nsamp);
    end
  endtask

  task automatic test_abort;
    // Abort during SETTLE of cell 3 (cycles 13..15)
    @(negedge clk);
    run_a(-1, -1, -1, -1, 14, 60);
    checks++;
    if (lg_view[14] !== loc_of(3)) begin
      errors++; $display("FAIL abort_settle_pre: got view %h expected %h", lg_view[14], loc_of(3));
    end
    checks++;
    if ({lg_view[15], lg_valid[15], lg_busy[15]} !== 15'd0 || lg_busy[40] !== 1'b0) begin
      errors++; $display("FAIL abort_settle_idle: got view=%h valid=%b busy=%b busy40=%b expected 0",
                         lg_view[15], lg_valid[15], lg_busy[15], lg_busy[40]);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL abort_settle_done: got %0d pulses expected 0", done_cnt);
    end
    run_a(-1, -1, -1, -1, -1, 60);
    checks++;
    if (smp_loc[0] !== 13'd0 || smp_cyc[0] != 4 || done_cyc != 33) begin
      errors++; $display("FAIL abort_restart1: got loc %h cycle %0d done %0d expected 0 4 33",
                         smp_loc[0], smp_cyc[0], done_cyc);
    end
    // Abort coincident with the handshake of cell 1 in cycle 8
    run_a(-1, -1, -1, -1, 8, 60);
    checks++;
    if (lg_valid[8] !== 1'b1 || lg_sloc[8] !== loc_of(1)) begin
      errors++; $display("FAIL abort_hs_pre: got valid=%b sloc=%h expected 1 %h", lg_valid[8], lg_sloc[8], loc_of(1));
    end
    checks++;
    if ({lg_view[9], lg_valid[9], lg_busy[9]} !== 15'd0) begin
      errors++; $display("FAIL abort_hs_idle: got view=%h valid=%b busy=%b expected 0",
                         lg_view[9], lg_valid[9], lg_busy[9]);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL abort_hs_done: got %0d pulses expected 0", done_cnt);
    end
    run_a(-1, -1, -1, -1, -1, 60);
    checks++;
    if (smp_addr[0] !== 13'd0 || smp_loc[1] !== loc_of(1) || done_cyc != 33) begin
      errors++; $display("FAIL abort_restart2: got addr0 %0d loc1 %h done %0d expected 0 %h 33",
                         smp_addr[0], smp_loc[1], done_cyc, loc_of(1));
    end
  endtask

  task automatic test_start_handling;
    @(negedge clk);
    run_a(-1, -1, 10, 33, -1, 60);
    checks++;
    if (done_cyc != 33 || done_cnt != 1 || smp_cyc[7] != 32 || smp_addr[7] !== 13'd7) begin
      errors++; $display("FAIL start_ignored_timing: got done %0d count %0d last %0d addr %0d expected 33 1 32 7",
                         done_cyc, done_cnt, smp_cyc[7], smp_addr[7]);
    end
    checks++;
    if ({lg_busy[34], lg_busy[35], lg_valid[35]} !== 3'b000) begin
      errors++; $display("FAIL start_in_done: got busy34/35 valid35=%b expected 000",
                         {lg_busy[34], lg_busy[35], lg_valid[35]});
    end
    @(negedge clk);
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b0;
    checks++;
    if ({a_busy, a_valid} !== 2'b00) begin
      errors++; $display("FAIL start_with_abort: got busy/valid=%b expected 00", {a_busy, a_valid});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({a_busy, a_valid, a_view_loc} !== 15'd0) begin
      errors++; $display("FAIL start_with_abort_idle: got busy=%b valid=%b view=%h expected 0",
                         a_busy, a_valid, a_view_loc);
    end
    run_a(-1, -1, -1, -1, -1, 60);
    checks++;
    if (done_cyc != 33 || nsamp != 8) begin
      errors++; $display("FAIL start_after_ignored: got done %0d samples %0d expected 33 8", done_cyc, nsamp);
    end
  endtask

  task automatic test_row_wrap;
    int idx, done_at, last_addr, wraps;
    logic wrap_pend;
    idx = 0; done_at = -1; last_addr = -1; wraps = 0; wrap_pend = 1'b0;
    @(negedge clk);
    b_start = 1'b1; b_ready = 1'b1; b_abort = 1'b0;
    for (int c = 0; c < 12000 && done_at < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        b_start = 1'b0;
      end
      if (wrap_pend) begin
        wrap_pend = 1'b0;
        checks++;
        if (b_view_loc !== {7'd0, 6'd1}) begin
          errors++; $display("FAIL wrap_view_loc: got %h expected %h", b_view_loc, {7'd0, 6'd1});
        end
      end
      if (b_done) done_at = c;
      if (b_valid && b_ready) begin
        checks++;
        if (b_saddr !== 13'(idx)) begin
          errors++; $display("FAIL full_addr[%0d]: got %0d expected %0d", idx, b_saddr, idx);
        end
        if (b_sloc === {7'd79, 6'd0}) begin
          wrap_pend = 1'b1;
          wraps++;
        end
        last_addr = int'(b_saddr);
        idx++;
      end
    end
    b_start = 1'b0;
    checks++;
    if (done_at < 0) begin
      errors++; $display("FAIL full_timeout: got no done within 12000 cycles expected done at 9601");
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL wrap_seen: got %0d occurrences of cell {79,0} expected 1", wraps);
    end
    checks++;
    if (last_addr != 4799 || idx != 4800 || done_at != 9601) begin
      errors++; $display("FAIL full_last: got addr %0d samples %0d done %0d expected 4799 4800 9601",
                         last_addr, idx, done_at);
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    a_start = 1'b1; a_ready = 1'b1; a_abort = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_sloc !== loc_of(1) || a_saddr !== 13'd1) begin
      errors++; $display("FAIL reset_mid_pre: got valid=%b sloc=%h addr=%0d expected 1 %h 1",
                         a_valid, a_sloc, a_saddr, loc_of(1));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_view_loc, a_valid, a_sray, a_sloc, a_saddr, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_async: got loc=%h valid=%b ray=%h sloc=%h addr=%0d busy=%b done=%b expected all 0",
               a_view_loc, a_valid, a_sray, a_sloc, a_saddr, a_busy, a_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({a_busy, a_valid, a_done, a_view_loc} !== 16'd0) begin
      errors++; $display("FAIL reset_then_idle: got busy=%b valid=%b done=%b view=%h expected 0",
                         a_busy, a_valid, a_done, a_view_loc);
    end
    run_a(-1, -1, -1, -1, -1, 60);
    checks++;
    if (smp_loc[0] !== 13'd0 || done_cyc != 33) begin
      errors++; $display("FAIL reset_restart: got loc %h done %0d expected 0 33", smp_loc[0], done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_free_frame();
    test_backpressure();
    test_abort();
    test_start_handling();
    test_row_wrap();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
